// File: rtl/touch_adc_ctrl.sv
// AD7843-style touch ADC controller: pen-gated X/Y SPI conversion frames.
// Optional TOUCH_PEN_EVENT_EN adds pen_down / pen_up event pulses.
module touch_adc_ctrl #(
  parameter int CLK_DIV    = 16,
  parameter int SAMPLE_GAP = 50000
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        penirq_n_sync,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_dclk,
  output logic        adc_din,
  output logic [11:0] x_coord,
  output logic [11:0] y_coord,
  output logic        coord_valid,
  output logic        busy
`ifdef TOUCH_PEN_EVENT_EN
  ,
  output logic        pen_down,
  output logic        pen_up
`endif
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(SAMPLE_GAP + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, CONV_X, CONV_Y, DONE, GAP
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          ph_q, ph_d;
  logic [4:0]    p_q, p_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [11:0]   xs_q, xs_d, ys_q, ys_d;
  logic [11:0]   x_q, x_d, y_q, y_d;
  logic          cs_n_q, cs_n_d;
  logic          dclk_q, dclk_d;
  logic          din_q, din_d;
  logic          vld_q, vld_d;
  logic          div_end, conv_d;
  logic [7:0]    cmd_d;
`ifdef TOUCH_PEN_EVENT_EN
  logic          pd_q, pd_d, pu_q, pu_d;
`endif

  assign div_end = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ph_d    = ph_q;
    p_d     = p_q;
    gap_d   = gap_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    x_d     = x_q;
    y_d     = y_q;
`ifdef TOUCH_PEN_EVENT_EN
    pd_d    = 1'b0;
    pu_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!penirq_n_sync) begin
          state_d = SETUP;
          div_d   = '0;
`ifdef TOUCH_PEN_EVENT_EN
          pd_d    = 1'b1;
`endif
        end
      end
      SETUP: begin
        if (div_end) begin
          state_d = CONV_X;
          div_d   = '0;
          ph_d    = 1'b0;
          p_d     = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      CONV_X, CONV_Y: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          ph_d  = !ph_q;
          // low->high boundary is the DCLK rising edge: sample here
          if (!ph_q) begin
            if (p_q >= 5'd9 && p_q <= 5'd20) begin
              if (state_q == CONV_X) xs_d = {xs_q[10:0], adc_dout};
              else                   ys_d = {ys_q[10:0], adc_dout};
            end
          end else if (p_q == 5'd23) begin
            p_d = '0;
            if (state_q == CONV_X) begin
              state_d = CONV_Y;
            end else begin
              state_d = DONE;
              x_d     = xs_q;
              y_d     = ys_q;
            end
          end else begin
            p_d = p_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = GAP;
        gap_d   = '0;
      end
      GAP: begin
        if (gap_q == GW'(SAMPLE_GAP - 1)) begin
          gap_d = '0;
          if (!penirq_n_sync) begin
            state_d = SETUP;
            div_d   = '0;
          end else begin
            state_d = IDLE;
`ifdef TOUCH_PEN_EVENT_EN
            pu_d    = 1'b1;
`endif
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin outputs are registered from next-state so they are glitch-free.
  always_comb begin
    conv_d = (state_d == CONV_X) || (state_d == CONV_Y);
    cmd_d  = (state_d == CONV_X) ? 8'hD0 : 8'h90;
    cs_n_d = !(conv_d || state_d == SETUP);
    dclk_d = conv_d && ph_d;
    din_d  = conv_d && (p_d < 5'd8) && cmd_d[~p_d[2:0]];
    vld_d  = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      ph_q    <= 1'b0;
      p_q     <= '0;
      gap_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cs_n_q  <= 1'b1;
      dclk_q  <= 1'b0;
      din_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      p_q     <= p_d;
      gap_q   <= gap_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cs_n_q  <= cs_n_d;
      dclk_q  <= dclk_d;
      din_q   <= din_d;
      vld_q   <= vld_d;
    end
  end

`ifdef TOUCH_PEN_EVENT_EN
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pd_q <= 1'b0;
      pu_q <= 1'b0;
    end else begin
      pd_q <= pd_d;
      pu_q <= pu_d;
    end
  end

  assign pen_down = pd_q;
  assign pen_up   = pu_q;
`endif

  assign adc_cs_n    = cs_n_q;
  assign adc_dclk    = dclk_q;
  assign adc_din     = din_q;
  assign x_coord     = x_q;
  assign y_coord     = y_q;
  assign coord_valid = vld_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_touch_adc_ctrl.sv
// Directed bench for touch_adc_ctrl with a behavioural AD7843 model.
// Pen-event checks are active when TOUCH_PEN_EVENT_EN is defined.
module tb_touch_adc_ctrl;

  localparam int CD     = 2;
  localparam int SG     = 10;
  localparam int FRAME  = CD + 96 * CD;
  localparam int PERIOD = SG + FRAME + 1;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        penirq_n_sync = 1'b1;
  logic        adc_dout = 1'b0;
  logic        adc_cs_n, adc_dclk, adc_din;
  logic [11:0] x_coord, y_coord;
  logic        coord_valid, busy;
`ifdef TOUCH_PEN_EVENT_EN
  logic        pen_down, pen_up;
  int          npd = 0, npu = 0;
`endif

  int          ncmp = 0, nerr = 0;
  int          cyc = 0;
  int          rises = 0, tot_rises = 0, nvld = 0;
  logic [47:0] din_cap = '0;
  logic [11:0] xv = '0, yv = '0;

  touch_adc_ctrl #(.CLK_DIV(CD), .SAMPLE_GAP(SG)) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .penirq_n_sync(penirq_n_sync),
    .adc_dout     (adc_dout),
    .adc_cs_n     (adc_cs_n),
    .adc_dclk     (adc_dclk),
    .adc_din      (adc_din),
    .x_coord      (x_coord),
    .y_coord      (y_coord),
    .coord_valid  (coord_valid),
    .busy         (busy)
`ifdef TOUCH_PEN_EVENT_EN
    ,
    .pen_down     (pen_down),
    .pen_up       (pen_up)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // ADC model: frame starts at CS fall; data for period n driven at DCLK fall
  always @(posedge adc_dclk or negedge adc_cs_n) begin
    if (adc_dclk) begin
      din_cap = {din_cap[46:0], adc_din};
      rises++;
      tot_rises++;
    end else begin
      rises   = 0;
      din_cap = '0;
    end
  end

  always @(negedge adc_dclk) begin
    int q;
    logic [11:0] v;
    q = rises % 24;
    v = (rises < 24) ? xv : yv;
    if (rises < 48 && q >= 9 && q <= 20) adc_dout = v[20-q];
    else adc_dout = 1'b0;
  end

  always @(negedge CLK) begin
    if (coord_valid) nvld++;
`ifdef TOUCH_PEN_EVENT_EN
    if (pen_down) npd++;
    if (pen_up) npu++;
`endif
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_vld(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLK);
      if (coord_valid) begin
        at = cyc;
        break;
      end
    end
    chk("vld_seen", 64'(at >= 0), 1);
  endtask

  task automatic wait_rises(input int n, input int lim);
    for (int i = 0; i < lim && rises < n; i++) @(negedge CLK);
    chk("rise_reach", 64'(rises >= n), 1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // Start a frame from IDLE; returns the cycle count of the leaving edge.
  task automatic pen_touch(output int k);
    penirq_n_sync = 1'b0;
    @(negedge CLK);
    k = cyc;
    chk("left_idle", 64'(busy), 1);
  endtask

  initial begin
    int k, t1, t2, t3, bad, n0, r0;

    // reset with pen already down
    penirq_n_sync = 1'b0;
    wait_cycles(3);
    chk("rst_cs_n", 64'(adc_cs_n), 1);
    chk("rst_dclk", 64'(adc_dclk), 0);
    chk("rst_din",  64'(adc_din), 0);
    chk("rst_x",    64'(x_coord), 0);
    chk("rst_y",    64'(y_coord), 0);
    chk("rst_vld",  64'(coord_valid), 0);
    chk("rst_busy", 64'(busy), 0);

    // single touch
    xv = 12'hA5C;
    yv = 12'h3F1;
    RST_n = 1'b1;
    @(negedge CLK);
    k = cyc;
    chk("setup_busy", 64'(busy), 1);
    chk("setup_cs_n", 64'(adc_cs_n), 0);
    chk("setup_dclk", 64'(adc_dclk), 0);
    penirq_n_sync = 1'b1;
    wait_vld(400, t1);
    chk("lat", 64'(t1 - k), 64'(FRAME));
    chk("x1", 64'(x_coord), 64'h A5C);
    chk("y1", 64'(y_coord), 64'h 3F1);
    chk("rises1", 64'(rises), 48);
    chk("din1", 64'(din_cap), 64'h D0_0000_90_0000);
    chk("done_cs_n", 64'(adc_cs_n), 1);
    @(negedge CLK);
    chk("vld_width", 64'(coord_valid), 0);
    wait_cycles(SG + 2);
    chk("idle1_busy", 64'(busy), 0);
    chk("nvld1", 64'(nvld), 1);

    // held pen: three frames
    xv = 12'h123;
    yv = 12'hC4E;
    bad = 0;
    pen_touch(k);
    wait_vld(400, t1);
    for (int i = 0; i <= SG; i++) begin
      if (!adc_cs_n) bad++;
      @(negedge CLK);
    end
    wait_vld(400, t2);
    for (int i = 0; i <= SG; i++) begin
      if (!adc_cs_n) bad++;
      @(negedge CLK);
    end
    wait_vld(400, t3);
    penirq_n_sync = 1'b1;
    for (int i = 0; i <= SG; i++) begin
      if (!adc_cs_n) bad++;
      @(negedge CLK);
    end
    chk("per12", 64'(t2 - t1), 64'(PERIOD));
    chk("per23", 64'(t3 - t2), 64'(PERIOD));
    chk("gap_cs_n", 64'(bad), 0);
    chk("x_held", 64'(x_coord), 64'h123);
    chk("y_held", 64'(y_coord), 64'hC4E);
    wait_cycles(3);
    chk("held_idle", 64'(busy), 0);

    // pen release during CONV_Y p=5
    xv = 12'h7E4;
    yv = 12'h05A;
    pen_touch(k);
    wait_rises(30, 400);
    penirq_n_sync = 1'b1;
    n0 = nvld;
    wait_vld(400, t1);
    chk("x_rel", 64'(x_coord), 64'h7E4);
    chk("y_rel", 64'(y_coord), 64'h05A);
    wait_cycles(SG + 3);
    chk("rel_busy", 64'(busy), 0);
    r0 = tot_rises;
    wait_cycles(60);
    chk("rel_no_dclk", 64'(tot_rises), 64'(r0));
    chk("rel_nvld", 64'(nvld), 64'(n0 + 1));

    // reset mid-frame at p=12 of CONV_X
    xv = 12'h999;
    yv = 12'h666;
    n0 = nvld;
    pen_touch(k);
    wait_rises(13, 400);
    #1 RST_n = 1'b0;
    #1;
    chk("mid_cs_n", 64'(adc_cs_n), 1);
    chk("mid_dclk", 64'(adc_dclk), 0);
    chk("mid_x", 64'(x_coord), 0);
    chk("mid_y", 64'(y_coord), 0);
    penirq_n_sync = 1'b1;
    wait_cycles(3);
    RST_n = 1'b1;
    wait_cycles(300);
    chk("mid_nvld", 64'(nvld), 64'(n0));
    chk("mid_busy", 64'(busy), 0);
    chk("mid_x2", 64'(x_coord), 0);

    // extreme values, both orientations
    for (int j = 0; j < 2; j++) begin
      xv = (j == 0) ? 12'hFFF : 12'h000;
      yv = (j == 0) ? 12'h000 : 12'hFFF;
`ifdef TOUCH_PEN_EVENT_EN
      npd = 0;
      npu = 0;
`endif
      pen_touch(k);
      penirq_n_sync = 1'b1;
      wait_vld(400, t1);
      chk("x_ext", 64'(x_coord), 64'(xv));
      chk("y_ext", 64'(y_coord), 64'(yv));
      wait_cycles(SG + 3);
      chk("ext_busy", 64'(busy), 0);
`ifdef TOUCH_PEN_EVENT_EN
      chk("pen_down_n", 64'(npd), 1);
      chk("pen_up_n", 64'(npu), 1);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
